// File: rtl/regfile_sb_pkg.sv
// Shared constants for the register file / scoreboard slice.
// Decode and the writeback stage use the same definitions.
package regfile_sb_pkg;
  localparam int NREG_DEF = 32;
  localparam int AW_DEF   = 5;
  localparam int DW_DEF   = 32;
  localparam int CNTW_DEF = 2;

  localparam logic [AW_DEF-1:0] REG_ZERO = '0;
endpackage

// File: rtl/regfile_sb_cnt.sv
// Pending-write counter for one architectural register.
// Saturates instead of wrapping; clear has priority over inc/dec.
module regfile_sb_cnt #(
  parameter int CNTW = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            inc_i,
  input  logic            dec_i,
  input  logic            clr_i,
  output logic [CNTW-1:0] cnt_o,
  output logic            sat_o
);
  logic [CNTW-1:0] cnt_q, cnt_d;

  assign sat_o = &cnt_q;
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && !dec_i && !sat_o)
      cnt_d = cnt_q + CNTW'(1);
    else if (dec_i && !inc_i && (cnt_q != '0))
      cnt_d = cnt_q - CNTW'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/regfile_sb.sv
// Architectural register file with write-through bypass and a per-register
// pending-write scoreboard that stalls decode on unresolved operands.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF,
  parameter int CNTW = CNTW_DEF
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_wb_regWe,
  input  logic [AW-1:0] i_wb_WRA,
  input  logic [DW-1:0] i_wb_WRD,
  input  logic [AW-1:0] i_rs_addr,
  input  logic [AW-1:0] i_rt_addr,
  output logic [DW-1:0] o_rs_data,
  output logic [DW-1:0] o_rt_data,
  input  logic          i_iss_valid,
  input  logic          i_iss_we,
  input  logic [AW-1:0] i_iss_dst,
  input  logic          i_rs_used,
  input  logic          i_rt_used,
  input  logic          i_flush,
  output logic          o_stall
);
  localparam logic [AW-1:0] RZ = AW'(REG_ZERO);

  logic [DW-1:0]   regs_q [NREG];
  logic [CNTW-1:0] pend   [NREG];
  logic            sat    [NREG];
  logic            wb_en;
  logic            busy_rs, busy_rt;

  assign wb_en   = i_wb_regWe && (i_wb_WRA != RZ);
  assign pend[0] = '0;
  assign sat[0]  = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    logic inc, dec;
    assign inc = i_iss_valid && !o_stall && i_iss_we && (i_iss_dst == AW'(r));
    assign dec = i_wb_regWe && (i_wb_WRA == AW'(r)) && (pend[r] != '0);

    regfile_sb_cnt #(.CNTW(CNTW)) u_cnt (
      .clk   (clk),
      .rstn  (rstn),
      .inc_i (inc),
      .dec_i (dec),
      .clr_i (i_flush),
      .cnt_o (pend[r]),
      .sat_o (sat[r])
    );
  end

  // A last outstanding write landing this cycle is covered by the bypass.
  function automatic logic busy_f(input logic [AW-1:0] a, input logic [CNTW-1:0] p,
                                  input logic we, input logic [AW-1:0] wra);
    return (p != '0) && !(we && (wra == a) && (p == CNTW'(1)));
  endfunction

  assign busy_rs = busy_f(i_rs_addr, pend[i_rs_addr], i_wb_regWe, i_wb_WRA);
  assign busy_rt = busy_f(i_rt_addr, pend[i_rt_addr], i_wb_regWe, i_wb_WRA);

  assign o_stall = i_iss_valid && !i_flush &&
                   ((i_rs_used && busy_rs) ||
                    (i_rt_used && busy_rt) ||
                    (i_iss_we && (i_iss_dst != RZ) && sat[i_iss_dst]));

  always_comb begin
    o_rs_data = regs_q[i_rs_addr];
    if (i_rs_addr == RZ)
      o_rs_data = '0;
    else if (wb_en && (i_wb_WRA == i_rs_addr))
      o_rs_data = i_wb_WRD;
  end

  always_comb begin
    o_rt_data = regs_q[i_rt_addr];
    if (i_rt_addr == RZ)
      o_rt_data = '0;
    else if (wb_en && (i_wb_WRA == i_rt_addr))
      o_rt_data = i_wb_WRD;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wb_en) begin
      regs_q[i_wb_WRA] <= i_wb_WRD;
    end
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: vector table plus hand-written
// sequences for flush and asynchronous reset during a stall.
module tb_regfile_sb;
  logic        clk = 1'b0;
  logic        rstn;
  logic        i_wb_regWe;
  logic [4:0]  i_wb_WRA;
  logic [31:0] i_wb_WRD;
  logic [4:0]  i_rs_addr, i_rt_addr;
  logic [31:0] o_rs_data, o_rt_data;
  logic        i_iss_valid, i_iss_we;
  logic [4:0]  i_iss_dst;
  logic        i_rs_used, i_rt_used, i_flush;
  logic        o_stall;

  regfile_sb dut (
    .clk        (clk),
    .rstn       (rstn),
    .i_wb_regWe (i_wb_regWe),
    .i_wb_WRA   (i_wb_WRA),
    .i_wb_WRD   (i_wb_WRD),
    .i_rs_addr  (i_rs_addr),
    .i_rt_addr  (i_rt_addr),
    .o_rs_data  (o_rs_data),
    .o_rt_data  (o_rt_data),
    .i_iss_valid(i_iss_valid),
    .i_iss_we   (i_iss_we),
    .i_iss_dst  (i_iss_dst),
    .i_rs_used  (i_rs_used),
    .i_rt_used  (i_rt_used),
    .i_flush    (i_flush),
    .o_stall    (o_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wra;
    logic [31:0] wrd;
    logic [4:0]  rs, rt;
    logic        iv, iwe;
    logic [4:0]  dst;
    logic        rsu, rtu, fl;
    logic [31:0] ers, ert;
    logic        est;
  } vec_t;

  typedef struct {
    logic [31:0] rs, rt;
    logic        stall;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   step_no = 0;

  function automatic vec_t mk(logic we, logic [4:0] wra, logic [31:0] wrd,
                              logic [4:0] rs, logic [4:0] rt, logic iv, logic iwe,
                              logic [4:0] dst, logic rsu, logic rtu, logic fl,
                              logic [31:0] ers, logic [31:0] ert, logic est);
    vec_t v;
    v.we = we; v.wra = wra; v.wrd = wrd; v.rs = rs; v.rt = rt;
    v.iv = iv; v.iwe = iwe; v.dst = dst; v.rsu = rsu; v.rtu = rtu; v.fl = fl;
    v.ers = ers; v.ert = ert; v.est = est;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s step %0d: got %h want %h", nm, idx, got, exp);
  endtask

  task automatic drive(input vec_t v);
    i_wb_regWe = v.we;  i_wb_WRA = v.wra; i_wb_WRD = v.wrd;
    i_rs_addr  = v.rs;  i_rt_addr = v.rt;
    i_iss_valid = v.iv; i_iss_we = v.iwe; i_iss_dst = v.dst;
    i_rs_used  = v.rsu; i_rt_used = v.rtu; i_flush = v.fl;
  endtask

  task automatic compare_front();
    exp_t e;
    if (sb.size() == 0) begin
      n_total++;
      $display("FAIL scoreboard step %0d: got empty want entry", step_no);
      return;
    end
    e = sb.pop_front();
    chk("rs_data", step_no, o_rs_data, e.rs);
    chk("rt_data", step_no, o_rt_data, e.rt);
    chk("stall",   step_no, {31'd0, o_stall}, {31'd0, e.stall});
  endtask

  task automatic step(input vec_t v);
    exp_t e;
    @(posedge clk);
    #1;
    drive(v);
    e.rs = v.ers; e.rt = v.ert; e.stall = v.est;
    sb.push_back(e);
    #3;
    compare_front();
    step_no++;
  endtask

  initial begin
    //         we wra  wrd           rs  rt  iv iwe dst rsu rtu fl  ers           ert           est
    vecs.push_back(mk(1'b0, 5'd0, 32'h0,        5'd5, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0));
    vecs.push_back(mk(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0));
    vecs.push_back(mk(1'b1, 5'd0, 32'h1234,     5'd5, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0));
    vecs.push_back(mk(1'b0, 5'd0, 32'h0,        5'd5, 5'd0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0));
    vecs.push_back(mk(1'b0, 5'd0, 32'h0,        5'd7, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1));
    vecs.push_back(mk(1'b1, 5'd7, 32'hA5A50007, 5'd7, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'hA5A50007, 32'h0,        1'b0));
    vecs.push_back(mk(1'b0, 5'd0, 32'h0,        5'd7, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'hA5A50007, 32'h0,        1'b0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1'b0, 5'd0, 32'h0,      5'd5, 5'd0, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0));
    vecs.push_back(mk(1'b0, 5'd0, 32'h0,        5'd5, 5'd0, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0,        1'b1));
    vecs.push_back(mk(1'b1, 5'd3, 32'h33,       5'd3, 5'd5, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 32'h33,       32'hDEADBEEF, 1'b1));
    vecs.push_back(mk(1'b0, 5'd0, 32'h0,        5'd3, 5'd5, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 32'h33,       32'hDEADBEEF, 1'b0));
    vecs.push_back(mk(1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0));
    vecs.push_back(mk(1'b1, 5'd9, 32'h99,       5'd9, 5'd0, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 32'h99,       32'h0,        1'b0));
    vecs.push_back(mk(1'b0, 5'd0, 32'h0,        5'd9, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h99,       32'h0,        1'b1));
    vecs.push_back(mk(1'b0, 5'd0, 32'h0,        5'd0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h33,       1'b1));
    vecs.push_back(mk(1'b1, 5'd4, 32'h44,       5'd9, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 32'h99,       32'h0,        1'b0));
    vecs.push_back(mk(1'b0, 5'd0, 32'h0,        5'd9, 5'd3, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 32'h99,       32'h33,       1'b0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1'b0, 5'd0, 32'h0,      5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0));
    vecs.push_back(mk(1'b1, 5'd12, 32'h12,      5'd12, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h12,      32'h0,        1'b0));
    vecs.push_back(mk(1'b0, 5'd0, 32'h0,        5'd12, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h12,      32'h0,        1'b0));

    // Reset state: reads zero, no stall even with operands in use.
    rstn = 1'b0;
    drive(mk(1'b0, 5'd0, 32'h0, 5'd1, 5'd31, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0));
    #3;
    chk("reset_rs",    step_no, o_rs_data, 32'h0);
    chk("reset_rt",    step_no, o_rt_data, 32'h0);
    chk("reset_stall", step_no, {31'd0, o_stall}, 32'h0);
    #9 rstn = 1'b1;

    foreach (vecs[i]) step(vecs[i]);

    // Flush with pend[4]=2, pend[6]=1 and a writeback to r4 in the same cycle.
    step(mk(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0));
    step(mk(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0));
    step(mk(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0));
    step(mk(1'b0, 5'd0, 32'h0, 5'd4, 5'd6, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 32'h44, 32'h0, 1'b1));
    step(mk(1'b1, 5'd4, 32'h4444, 5'd4, 5'd0, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b1, 32'h4444, 32'h0, 1'b0));
    step(mk(1'b0, 5'd0, 32'h0, 5'd4, 5'd6, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 32'h4444, 32'h0, 1'b0));

    // Asynchronous reset in the middle of a stall.
    step(mk(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd10, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0));
    step(mk(1'b0, 5'd0, 32'h0, 5'd10, 5'd5, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0, 32'hDEADBEEF, 1'b1));
    #1 rstn = 1'b0;
    #1;
    chk("rst_mid_stall", step_no, {31'd0, o_stall}, 32'h0);
    chk("rst_mid_rt",    step_no, o_rt_data, 32'h0);
    chk("rst_mid_rs",    step_no, o_rs_data, 32'h0);
    #2 rstn = 1'b1;
    step(mk(1'b0, 5'd0, 32'h0, 5'd10, 5'd5, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0));

    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Architectural register file plus per-register pending-write scoreboard.
- Sink for the writeback interface (regWe / WRA / write data) driven by the final pipeline stage. Source of operands for decode.
- Tracks in-flight writes issued by decode. Raises a stall when a source operand is still pending. Clears pending state on writeback or flush.

Parameters:
- NREG, 32, number of architectural registers; register 0 is hardwired zero.
- AW, 5, register address width (log2 NREG).
- DW, 32, data width.
- CNTW, 2, width of per-register pending-write counter; maximum in-flight writes to one register is 2^CNTW-1.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- i_wb_regWe  in  1  writeback enable from final stage.
- i_wb_WRA  in  AW  writeback register address.
- i_wb_WRD  in  DW  writeback data.
- i_rs_addr  in  AW  read port A address.
- i_rt_addr  in  AW  read port B address.
- o_rs_data  out  DW  read port A data.
- o_rt_data  out  DW  read port B data.
- i_iss_valid  in  1  decode issues an instruction this cycle.
- i_iss_we  in  1  the issued instruction writes a register.
- i_iss_dst  in  AW  destination of the issued instruction.
- i_rs_used, i_rt_used  in  1 each  issued instruction reads rs/rt.
- i_flush  in  1  squash all in-flight writes (branch/exception).
- o_stall  out  1  decode must hold; issue is not accepted.

Behaviour:
- Reset (rstn low, asynchronous): all registers = 0; all pending counters = 0. o_stall = 0 once counters are clear. Read data is combinational from the cleared array, so it is 0. Reset mid-operation discards all pending state immediately.
- Write: at posedge, if i_wb_regWe && i_wb_WRA != 0, reg[WRA] <= WRD. Writes to address 0 are ignored.
- Read: combinational, zero added latency.
  - Address 0 returns 0.
  - If i_wb_regWe && i_wb_WRA == addr && addr != 0, return i_wb_WRD (write-through bypass, same cycle).
  - Otherwise return reg[addr].
- Pending counter pend[r], r = 1..NREG-1. Per-cycle events:
  - inc = i_iss_valid && !o_stall && i_iss_we && i_iss_dst == r.
  - dec = i_wb_regWe && i_wb_WRA == r && pend[r] != 0.
  - inc && dec: pend[r] unchanged. inc only: +1. dec only: -1.
  - Writeback to a register with pend = 0 writes data and leaves the counter at 0 (no underflow).
- Flush: at posedge with i_flush = 1, all pend <= 0, overriding same-cycle inc/dec. The register write from writeback still occurs.
- pend[0] is constant 0; issue with dst = 0 never sets busy.
- Busy (combinational): busy(r) = pend[r] != 0 && !(i_wb_regWe && i_wb_WRA == r && pend[r] == 1). The last outstanding write landing this cycle is treated as bypassed.
- o_stall = i_iss_valid && !i_flush && any of:
  - i_rs_used && busy(rs)
  - i_rt_used && busy(rt)
  - i_iss_we && i_iss_dst != 0 && pend[dst] == all-ones (counter saturated)
- o_stall is combinational. A stalled issue does not increment.
- Counters never wrap: saturation stalls instead.

Decomposition:
- Shared package: AW/DW/NREG constants and REG_ZERO = 0 address constant, used by decode and the writeback stage.
- One natural sub-module: regfile_sb_cnt, a single pending counter with inc/dec/clr and saturation flag. Instantiate NREG-1 times via generate. Array and bypass muxes stay in the top module.

Test Plan:
- Reset then read r1, r31 -> both 0; o_stall = 0 with any issue.
- wb_regWe = 1, WRA = 5, WRD = 0xDEADBEEF, rs_addr = 5 same cycle -> o_rs_data = 0xDEADBEEF that cycle and all later cycles. WRA = 0, WRD = 0x1234 -> r0 still reads 0.
- Issue dst = 7, next cycle issue with rs = 7, rs_used = 1 -> o_stall = 1. Writeback WRA = 7 arrives -> o_stall drops in that same cycle and o_rs_data equals the written data.
- Issue dst = 3 three times (CNTW = 2), fourth issue to dst = 3 -> o_stall = 1. One writeback to 3 -> fourth issue accepted the next cycle.
- Same cycle: issue dst = 9 and writeback WRA = 9 with pend[9] = 1 -> pend[9] stays 1, and a subsequent rs = 9 read stalls.
- pend[4] = 2 and pend[6] = 1, assert i_flush with a writeback to 4 -> all counters 0, r4 updated. Reset asserted mid-stall -> o_stall = 0 and registers 0 asynchronously.
